mem_bist: RTL and testbench

- Initiator-side engine that drives the 16x2 synchronous memory port (we, addr, d_in) and consumes its registered read data (d_out).
- Writes a seed-derived pattern to every address, reads each address back, and compares the result.
- Reports pass/fail, the first failing address and an error count.
- Sits between the trainer's control logic and the memory instance; the memory needs no changes.

---
 rtl/mem_bist_pkg.sv | 32 +++
 rtl/mem_bist_chk.sv | 70 +++++++
 rtl/mem_bist.sv | 146 ++++++++++++++
 tb/tb_mem_bist.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bist_pkg.sv
// Shared constants, FSM state type and pattern helper for the mem_bist engine.
// Optional second inverted pass is enabled by defining MEM_BIST_INV_PASS_EN.
package mem_bist_pkg;

  localparam int AW    = 4;
  localparam int DW    = 2;
  localparam int DEPTH = 16;
  localparam int ERR_W = 5;

  localparam logic [ERR_W-1:0] ERR_MAX   = 5'd31;
  localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } state_t;

  // State plus the inverted-phase flag used when the second pass is built in.
  typedef struct packed {
    state_t st;
    logic   inv;
  } phase_t;

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a,
                                            input logic [DW-1:0] s);
    return a[DW-1:0] ^ s;
  endfunction

endpackage

// File: rtl/mem_bist_chk.sv
// Read-compare stage: one-deep pipeline holding the expected word, mismatch
// detection, saturating error counter and first-failure address capture.
module mem_bist_chk
  import mem_bist_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             vld,
  input  logic [DW-1:0]    exp,
  input  logic [AW-1:0]    addr,
  input  logic [DW-1:0]    rdata,
  output logic [ERR_W-1:0] err_count,
  output logic [AW-1:0]    fail_addr,
  output logic             clean
);

  logic          rd_vld_q;
  logic [DW-1:0] exp_q;
  logic [AW-1:0] addr_q;
  logic          first_q;
  logic          mismatch;

  // Compare the registered read data against the word expected one cycle earlier.
  always_comb begin
    mismatch = rd_vld_q && (rdata != exp_q);
    clean    = (err_count == '0) && !mismatch;
  end

  // Pipeline register aligning the expectation with the memory read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= 1'b0;
      exp_q    <= '0;
      addr_q   <= '0;
    end else if (clear) begin
      rd_vld_q <= 1'b0;
      exp_q    <= '0;
      addr_q   <= '0;
    end else begin
      rd_vld_q <= vld;
      if (vld) begin
        exp_q  <= exp;
        addr_q <= addr;
      end
    end
  end

  // Error accounting; only the first mismatch records its address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
      fail_addr <= '0;
      first_q   <= 1'b0;
    end else if (clear) begin
      err_count <= '0;
      fail_addr <= '0;
      first_q   <= 1'b0;
    end else if (mismatch) begin
      if (err_count != ERR_MAX) begin
        err_count <= err_count + ERR_W'(1);
      end
      if (!first_q) begin
        first_q   <= 1'b1;
        fail_addr <= addr_q;
      end
    end
  end

endmodule

// File: rtl/mem_bist.sv
// March-style write/read/compare BIST engine for a 16x2 registered-read memory.
// Define MEM_BIST_INV_PASS_EN to add a second pass with inverted data.
module mem_bist
  import mem_bist_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DW-1:0]    seed,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [AW-1:0]    fail_addr,
  output logic [4:0]       err_count
);

  state_t        state;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_nxt;
  logic [DW-1:0] seed_q;
  logic [DW-1:0] inv_mask;
  logic          accept;
  logic          issue;
  logic          clean;

`ifdef MEM_BIST_INV_PASS_EN
  logic inv_q;
`endif

  // Next address, start acceptance and the data polarity of the current pass.
  always_comb begin
    cnt_nxt  = cnt + AW'(1);
    accept   = (state == IDLE) && start;
    issue    = (state == RD);
    inv_mask = '0;
`ifdef MEM_BIST_INV_PASS_EN
    inv_mask = {DW{inv_q}};
`endif
  end

  mem_bist_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (accept),
    .vld       (issue),
    .exp       (pattern(cnt, seed_q) ^ inv_mask),
    .addr      (cnt),
    .rdata     (mem_rdata),
    .err_count (err_count),
    .fail_addr (fail_addr),
    .clean     (clean)
  );

  // Sequencer; memory port values are registered for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      seed_q    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
`ifdef MEM_BIST_INV_PASS_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          mem_we <= 1'b0;
          if (start) begin
            seed_q    <= seed;
            cnt       <= '0;
            busy      <= 1'b1;
            pass      <= 1'b0;
            mem_we    <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= pattern('0, seed);
            state     <= WR;
`ifdef MEM_BIST_INV_PASS_EN
            inv_q     <= 1'b0;
`endif
          end
        end
        WR: begin
          if (cnt == LAST_ADDR) begin
            cnt      <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            state    <= RD;
          end else begin
            cnt       <= cnt_nxt;
            mem_addr  <= cnt_nxt;
            mem_wdata <= pattern(cnt_nxt, seed_q) ^ inv_mask;
          end
        end
        RD: begin
          if (cnt == LAST_ADDR) begin
            state <= DRAIN;
          end else begin
            cnt      <= cnt_nxt;
            mem_addr <= cnt_nxt;
          end
        end
        DRAIN: begin
`ifdef MEM_BIST_INV_PASS_EN
          if (!inv_q) begin
            inv_q     <= 1'b1;
            cnt       <= '0;
            mem_we    <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= ~pattern('0, seed_q);
            state     <= WR;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= clean;
            state <= FIN;
          end
`else
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= clean;
          state <= FIN;
`endif
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          busy   <= 1'b0;
          mem_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bist.sv
// Randomised scoreboard bench for mem_bist with a fault-injecting memory model.
// Honours MEM_BIST_INV_PASS_EN to expect the second inverted pass.
module tb_mem_bist;
  import mem_bist_pkg::*;

`ifdef MEM_BIST_INV_PASS_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif
  localparam int BUSY_LEN = NPASS * (2 * DEPTH + 1);
  localparam int DMAX = (1 << DW) - 1;

  typedef struct {
    int err;
    int faddr;
    int pass;
    int lat;
    int busy;
    int start_cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] seed = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy, done, pass;
  logic [AW-1:0] fail_addr;
  logic [4:0]    err_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_n = 0;
  int last_seed = 0;
  exp_t q[$];

  logic [DW-1:0] mem [DEPTH];
  int s1 [DEPTH];
  int s0 [DEPTH];

  always #5 clk = ~clk;

  mem_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .err_count(err_count)
  );

  // Memory with per-address stuck-at-1 / stuck-at-0 masks applied on read
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= DW'((int'(mem[mem_addr]) | s1[mem_addr]) & ~s0[mem_addr]);
  end

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic int word_of(input int k, input int sd, input int p);
    int w;
    w = (k % (DMAX + 1)) ^ sd;
    if (p == 1) w = DMAX - w;
    return w;
  endfunction

  // Whole-test result from the stored pattern and the fault map
  function automatic exp_t model(input int sd, input int sc);
    exp_t e;
    int n = 0;
    int first = 0;
    for (int p = 0; p < NPASS; p++) begin
      for (int k = 0; k < DEPTH; k++) begin
        int want = word_of(k, sd, p);
        int got = (want | s1[k]) & ~s0[k] & DMAX;
        if (got != want) begin
          if (n == 0) first = k;
          n++;
        end
      end
    end
    e.err = (n > 31) ? 31 : n;
    e.faddr = first;
    e.pass = (n == 0) ? 1 : 0;
    e.lat = BUSY_LEN + 1;
    e.busy = BUSY_LEN;
    e.start_cyc = sc;
    return e;
  endfunction

  // Monitor: pops one expectation per done pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_n = 0;
      end else begin
        if (busy) busy_n++;
        if (done) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = q.pop_front();
            chk("done_latency", cyc - e.start_cyc, e.lat);
            chk("busy_cycles", busy_n, e.busy);
            chk("busy_at_done", int'(busy), 0);
            chk("err_count", int'(err_count), e.err);
            chk("fail_addr", int'(fail_addr), e.faddr);
            chk("pass", int'(pass), e.pass);
          end
          busy_n = 0;
        end
      end
    end
  end

  task automatic clear_faults();
    for (int k = 0; k < DEPTH; k++) begin
      s1[k] = 0;
      s0[k] = 0;
    end
  endtask

  task automatic kick(input int sd);
    q.push_back(model(sd, cyc));
    last_seed = sd;
    seed = DW'(sd);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic check_image();
    int bad = 0;
    for (int k = 0; k < DEPTH; k++)
      if (int'(mem[k]) != word_of(k, last_seed, NPASS - 1)) bad++;
    chk("mem_image_bad_words", bad, 0);
  endtask

  task automatic run(input int sd);
    kick(sd);
    wait_done();
    @(negedge clk);
    check_image();
  endtask

  initial begin
    clear_faults();
    repeat (2) @(negedge clk);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_wdata", int'(mem_wdata), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_fail_addr", int'(fail_addr), 0);
    chk("rst_err_count", int'(err_count), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run(0);

    s1[4] = 1;
    run(0);

    clear_faults();
    s1[3] = 1;
    s1[9] = 1;
    run(3);

    clear_faults();
    s1[5] = 1;
    run(0);

    // Start while busy must not restart the run
    clear_faults();
    s0[7] = 2;
    kick(1);
    repeat (9) @(negedge clk);
    seed = 2'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    // Start during the done cycle is ignored as well
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("start_in_fin_busy", int'(busy), 0);
    chk("start_in_fin_mem_we", int'(mem_we), 0);

    // Reset in the middle of the write phase aborts with no done
    clear_faults();
    seed = 2'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_we", int'(mem_we), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_err_count", int'(err_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(0);

    for (int it = 0; it < 8; it++) begin
      int nf;
      clear_faults();
      nf = int'($urandom_range(0, 6));
      for (int f = 0; f < nf; f++) begin
        int a = int'($urandom_range(0, DEPTH - 1));
        int b = 1 << $urandom_range(0, DW - 1);
        if ($urandom_range(0, 1) == 0) s1[a] = s1[a] | b;
        else s0[a] = s0[a] | b;
      end
      for (int k = 0; k < DEPTH; k++) s0[k] = s0[k] & ~s1[k];
      run(int'($urandom_range(0, DMAX)));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
